// File: rtl/apb_pkg.sv
// apb_pkg: shared types and helpers for the wait-state APB memory slave.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam int CNT_W = 4;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/apb_bytewr_ram.sv
// apb_bytewr_ram: DEPTH x DATA_W array, synchronous byte-lane write, asynchronous read.
module apb_bytewr_ram import apb_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i)
        for (int i = 0; i < DATA_W/8; i++)
            if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/apb_ws_mem_slave.sv
// apb_ws_mem_slave: APB scratch-RAM slave with programmable wait states,
// byte strobes and PSLVERR on out-of-range word index.
module apb_ws_mem_slave import apb_pkg::*; #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NB  = DATA_W / 8;
    localparam int LSB = clog2(NB);
    localparam int IW  = ADDR_W - LSB;
    localparam int RW  = (DEPTH > 1) ? clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d, wdata_q, wdata_d, rdata, resp;
    logic [IW-1:0]     idx_q, idx_d, idx;
    logic [NB-1:0]     strb_q, strb_d;
    logic              write_q, write_d, wr, setup, oor, we, unused_addr;

    // A setup phase always wins, so the response of a zero-wait transfer is
    // built from the live bus while later responses use the captured request.
    assign setup       = psel && !penable;
    assign idx         = setup ? paddr[ADDR_W-1:LSB] : idx_q;
    assign wr          = setup ? pwrite : write_q;
    assign oor         = int'(idx) >= DEPTH;
    assign resp        = oor ? '0 : (wr ? prdata_q : rdata);
    assign unused_addr = ^paddr;

    apb_bytewr_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(RW)) u_ram (
        .clk_i  (pclk),
        .we_i   (we),
        .be_i   (strb_q),
        .addr_i (idx[RW-1:0]),
        .wdata_i(wdata_q),
        .rdata_o(rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        we        = 1'b0;
        if (setup) begin
            state_d   = ACCESS;
            cnt_d     = CNT_W'(WAIT_STATES);
            idx_d     = paddr[ADDR_W-1:LSB];
            write_d   = pwrite;
            wdata_d   = pwdata;
            strb_d    = pstrb;
            pready_d  = (WAIT_STATES == 0);
            pslverr_d = (WAIT_STATES == 0) && oor;
            prdata_d  = (WAIT_STATES == 0) ? resp : prdata_q;
        end else if (state_q == ACCESS) begin
            if (!psel || pready_q) begin
                we        = psel && pready_q && write_q && !oor;
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end else if (cnt_q > 1) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d     = '0;
                pready_d  = 1'b1;
                pslverr_d = oor;
                prdata_d  = resp;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ws_mem_slave.sv
// tb_apb_ws_mem_slave: scoreboard bench driving a zero-wait and a 3-wait slave
// against a word-array reference model.
module tb_apb_ws_mem_slave;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic        psel[2], penable[2], pwrite[2], pready[2], pslverr[2];
    logic [11:0] paddr[2];
    logic [31:0] pwdata[2], prdata[2];
    logic [3:0]  pstrb[2];

    apb_ws_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_ws_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    typedef struct {
        int          k;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[2][64];
    logic [31:0] ref_rd[2];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, req);
        end
    endfunction

    // Reference: word array plus the last read value the slave presents.
    function automatic exp_t model(int k, logic w, logic [11:0] a, logic [31:0] d, logic [3:0] s);
        exp_t r;
        int   i = int'(a) / 4;
        r.k = k;
        r.e = 1'b0;
        if (i >= 64) begin
            r.d = '0;
            r.e = 1'b1;
            ref_rd[k] = '0;
        end else if (w) begin
            r.d = ref_rd[k];
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[k][i][8*b +: 8] = d[8*b +: 8];
        end else begin
            r.d = ref_mem[k][i];
            ref_rd[k] = r.d;
        end
        return r;
    endfunction

    task automatic idle(int n);
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0;
            penable[k] = 1'b0;
        end
        repeat (n) @(posedge pclk) #1;
    endtask

    task automatic setup_phase(int k, logic w, logic [11:0] a, logic [31:0] d, logic [3:0] s);
        psel[1-k] = 1'b0;
        penable[1-k] = 1'b0;
        psel[k] = 1'b1;
        penable[k] = 1'b0;
        pwrite[k] = w;
        paddr[k] = a;
        pwdata[k] = d;
        pstrb[k] = s;
    endtask

    // Bus fields are scrambled after setup; the slave must use what it captured.
    task automatic scramble(int k);
        penable[k] = 1'b1;
        paddr[k] = 12'($urandom);
        pwdata[k] = $urandom;
        pstrb[k] = 4'($urandom);
        pwrite[k] = 1'($urandom);
    endtask

    task automatic xfer(int k, logic w, logic [11:0] a, logic [31:0] d, logic [3:0] s);
        int n;
        setup_phase(k, w, a, d, s);
        exp_q.push_back(model(k, w, a, d, s));
        @(posedge pclk) #1;
        scramble(k);
        n = 1;
        while (!pready[k] && n < 40) begin
            @(posedge pclk) #1;
            n++;
        end
        chk("access_cycles", k, 32'(n), (k == 1) ? 32'd4 : 32'd1);
        @(posedge pclk) #1;
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (presetn)
            for (int k = 0; k < 2; k++) begin
                if (pslverr[k] && !pready[k])
                    chk("pslverr_without_pready", k, 32'(pslverr[k]), 32'(pready[k]));
                if (pready[k]) begin
                    if (!(psel[k] && penable[k]))
                        chk("pready_outside_access", k, 32'(pready[k]), 32'(psel[k] && penable[k]));
                    else if (exp_q.size() == 0)
                        chk("unexpected_response", k, 32'(exp_q.size()), 32'd1);
                    else begin
                        e = exp_q.pop_front();
                        chk("response_dut", k, 32'(e.k), 32'(k));
                        chk("prdata", k, prdata[k], e.d);
                        chk("pslverr", k, 32'(pslverr[k]), 32'(e.e));
                    end
                end
            end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0;
            penable[k] = 1'b0;
            pwrite[k] = 1'b0;
            paddr[k] = '0;
            pwdata[k] = '0;
            pstrb[k] = '0;
            ref_rd[k] = '0;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_prdata", k, prdata[k], 32'h0);
            chk("reset_pready", k, 32'(pready[k]), 32'h0);
            chk("reset_pslverr", k, 32'(pslverr[k]), 32'h0);
        end
        presetn = 1'b1;
        idle(2);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++)
                xfer(k, 1'b1, 12'(i * 4), $urandom, 4'hF);
        idle(1);

        xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0);
        idle(1);
        xfer(1, 1'b0, 12'h004, 32'h0, 4'h0);
        idle(1);
        xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5);
        xfer(0, 1'b0, 12'h020, 32'h0, 4'h0);
        idle(1);
        xfer(0, 1'b1, 12'h100, 32'h55AA55AA, 4'hF);
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0);
        xfer(0, 1'b0, 12'h3FC, 32'h0, 4'h0);
        idle(1);

        setup_phase(1, 1'b1, 12'h008, 32'hCAFEF00D, 4'hF);
        @(posedge pclk) #1;
        scramble(1);
        @(posedge pclk) #1;
        psel[1] = 1'b0;
        penable[1] = 1'b0;
        @(posedge pclk) #1;
        chk("abort_pready", 1, 32'(pready[1]), 32'h0);
        chk("abort_pslverr", 1, 32'(pslverr[1]), 32'h0);
        xfer(1, 1'b0, 12'h008, 32'h0, 4'h0);
        xfer(1, 1'b1, 12'h008, 32'h600DD00D, 4'hF);
        xfer(1, 1'b0, 12'h008, 32'h0, 4'h0);
        idle(1);

        setup_phase(1, 1'b1, 12'h00C, 32'hBADC0FFE, 4'hF);
        @(posedge pclk) #1;
        scramble(1);
        @(posedge pclk) #1;
        presetn = 1'b0;
        psel[1] = 1'b0;
        penable[1] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midreset_prdata", k, prdata[k], 32'h0);
            chk("midreset_pready", k, 32'(pready[k]), 32'h0);
            chk("midreset_pslverr", k, 32'(pslverr[k]), 32'h0);
            ref_rd[k] = '0;
        end
        @(posedge pclk) #1;
        presetn = 1'b1;
        idle(1);
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0);
        xfer(1, 1'b1, 12'h00C, 32'h12345678, 4'hF);
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0);
        idle(1);

        repeat (200) begin
            int          k;
            logic [11:0] a;
            k = $urandom_range(0, 1);
            a = 12'($urandom_range(0, 319));
            if ($urandom_range(0, 9) == 0) a = 12'($urandom);
            xfer(k, 1'($urandom), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(5);
        chk("pending_responses", 0, 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
